// File: rtl/jk_counter_ctrl.sv
// Sequencing controller for a W-bit counter built from a bank of JK flip-flops.
// Reads back the bank's q and drives per-bit J/K to count, hold, load or clear.
module jk_counter_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         pause_i,
  input  logic         dir_i,
  input  logic         mode_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] tc_val_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] j_o,
  output logic [W-1:0] k_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         tc_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] toggleMask;
  logic         atTerm;
  logic [W-1:0] jNext, kNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
  always_comb begin
    toggleMask    = '0;
    toggleMask[0] = 1'b1;
    for (int i = 1; i < W; i++) begin
      toggleMask[i] = toggleMask[i-1] & (dir_i ? q_i[i-1] : ~q_i[i-1]);
    end
  end

  assign atTerm = dir_i ? (q_i == tc_val_i) : (q_i == '0);

  always_comb begin
    state_d = state_q;
    jNext   = '0;
    kNext   = '0;
    if (stop_i) begin
      kNext   = '1;
      state_d = IDLE;
    end else if (load_i) begin
      jNext = load_val_i;
      kNext = ~load_val_i;
      if (state_q == DONE) begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (atTerm) begin
            if (mode_i) begin
              state_d = DONE;
            end else if (dir_i) begin
              kNext = '1;
            end else begin
              jNext = tc_val_i;
              kNext = ~tc_val_i;
            end
          end else if (pause_i) begin
            state_d = PAUSE;
          end else begin
            jNext = toggleMask;
            kNext = toggleMask;
          end
        end
        IDLE, PAUSE, DONE: begin
          if (start_i) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so the bank sees no stray commands.
  always_comb begin
    j_o    = '0;
    k_o    = '0;
    busy_o = 1'b0;
    done_o = 1'b0;
    tc_o   = 1'b0;
    if (!reset) begin
      j_o    = jNext;
      k_o    = kNext;
      busy_o = (state_q == RUN) || (state_q == PAUSE);
      done_o = (state_q == DONE);
      tc_o   = (state_q == RUN) && atTerm;
    end
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Directed self-checking bench for jk_counter_ctrl driving a behavioural 4-bit JK bank.
module tb_jk_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, pause, dir, mode, load;
  logic [3:0] loadVal, tcVal, bankQ, jOut, kOut;
  logic       busy, done, tc;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  jk_counter_ctrl #(.W(4)) dut (
    .clk(clk), .reset(reset), .start_i(start), .stop_i(stop), .pause_i(pause),
    .dir_i(dir), .mode_i(mode), .load_i(load), .load_val_i(loadVal),
    .tc_val_i(tcVal), .q_i(bankQ), .j_o(jOut), .k_o(kOut),
    .busy_o(busy), .done_o(done), .tc_o(tc)
  );

  // Behavioural JK bank: the plant the controller steers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bankQ <= '0;
    else begin
      for (int i = 0; i < 4; i++) begin
        case ({jOut[i], kOut[i]})
          2'b01:   bankQ[i] <= 1'b0;
          2'b10:   bankQ[i] <= 1'b1;
          2'b11:   bankQ[i] <= ~bankQ[i];
          default: bankQ[i] <= bankQ[i];
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic st, input logic ld);
    start = s; pause = p; stop = st; load = ld;
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; pause = 0; dir = 1; mode = 0; load = 0;
    loadVal = 0; tcVal = 9;
    #2;
    applyStimulus(0, 0, 1, 0);
    checkOutput("rst_j", jOut, 4'h0);
    checkOutput("rst_k", kOut, 4'h0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_tc", tc, 0);
    applyStimulus(0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;

    $display("[TB] free-run up to tc_val=9");
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("up_busy", busy, 1);
    for (int n = 0; n < 12; n++) begin
      checkOutput($sformatf("up_q%0d", n), bankQ, n % 10);
      checkOutput($sformatf("up_tc%0d", n), tc, (n % 10) == 9);
      tick();
    end

    $display("[TB] one-shot down from 5");
    applyStimulus(0, 0, 1, 0);
    tick();
    dir = 0; mode = 1; tcVal = 5; loadVal = 5;
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("dn_q%0d", i), bankQ, 5 - i);
      checkOutput($sformatf("dn_tc%0d", i), tc, i == 5);
      checkOutput($sformatf("dn_busy%0d", i), busy, 1);
      tick();
    end
    checkOutput("dn_done", done, 1);
    checkOutput("dn_busy_end", busy, 0);
    checkOutput("dn_q_end", bankQ, 0);
    tick();
    checkOutput("dn_q_hold", bankQ, 0);
    checkOutput("dn_done_hold", done, 1);

    $display("[TB] pause and resume at 3");
    applyStimulus(0, 0, 1, 0);
    tick();
    dir = 1; mode = 0; tcVal = 15; loadVal = 3;
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 0);
    tick();
    checkOutput("ps_q_run", bankQ, 3);
    applyStimulus(0, 1, 0, 0);
    tick();
    checkOutput("ps_q_p1", bankQ, 3);
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("ps_q_p2", bankQ, 3);
    checkOutput("ps_busy", busy, 1);
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("ps_q_resume", bankQ, 3);
    tick();
    checkOutput("ps_q_next", bankQ, 4);

    $display("[TB] stop beats load");
    tick(); tick(); tick();
    checkOutput("sl_q7", bankQ, 7);
    loadVal = 4'hA;
    applyStimulus(0, 0, 1, 1);
    checkOutput("sl_j", jOut, 4'h0);
    checkOutput("sl_k", kOut, 4'hF);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("sl_q", bankQ, 0);
    checkOutput("sl_busy", busy, 0);

    $display("[TB] carry ripple and wrap at 15");
    loadVal = 7;
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("cr_j", jOut, 4'hF);
    checkOutput("cr_k", kOut, 4'hF);
    tick();
    checkOutput("cr_q8", bankQ, 8);
    loadVal = 4'hF;
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("wr_q15", bankQ, 15);
    checkOutput("wr_tc", tc, 1);
    checkOutput("wr_j", jOut, 4'h0);
    checkOutput("wr_k", kOut, 4'hF);
    tick();
    checkOutput("wr_q0", bankQ, 0);
    checkOutput("wr_tc0", tc, 0);

    $display("[TB] async reset mid-run");
    loadVal = 6;
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("ar_q6", bankQ, 6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_j", jOut, 0);
    checkOutput("ar_k", kOut, 0);
    checkOutput("ar_done", done, 0);
    checkOutput("ar_tc", tc, 0);
    checkOutput("ar_q", bankQ, 0);
    tick();
    reset = 1'b0;

    $display("[TB] tc_val=0 one-shot up");
    dir = 1; mode = 1; tcVal = 0;
    applyStimulus(1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("z_tc", tc, 1);
    tick();
    checkOutput("z_done", done, 1);
    checkOutput("z_q", bankQ, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
